serial_tx_framer: RTL and testbench

SERIAL_TX_FRAMER -- requirements
Module: serial_tx_framer

---
 rtl/serial_tx_pkg.sv | 23 ++
 rtl/bit_timer.sv | 46 ++++
 rtl/serial_tx_framer.sv | 123 ++++++++++++
 tb/tb_serial_tx_framer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// Shared types and default parameters for the serial transmit framer.
// The state encoding is shared by the top-level FSM and any debug tooling.
package serial_tx_pkg;

  localparam int DEF_DATA_W       = 8;
  localparam int DEF_CLKS_PER_BIT = 4;
  localparam int DEF_LSB_FIRST    = 1;
  localparam int DEF_PARITY_EN    = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Counter width for a modulus of n; a modulus of 1 still needs one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period counter for the framer: counts 0..CLKS_PER_BIT-1 while a frame is active.
// tick_first is a registered flag high in the first cycle of every period.
module bit_timer
  import serial_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic active_next,
  output logic tick_first,
  output logic tick_last,
  output logic tick_next_last
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             first_q;

  // A period restarts from 0 whenever the frame is (re)entered or the count wraps.
  always_comb begin
    cnt_d = '0;
    if (active && active_next && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      first_q <= active_next && (cnt_d == '0);
    end
  end

  assign tick_first     = first_q;
  assign tick_last      = (cnt_q == LAST);
  assign tick_next_last = active_next && (cnt_d == LAST);

endmodule

// File: rtl/serial_tx_framer.sv
// Parallel-to-serial framer: start bit, DATA_W data bits, optional even parity, stop bit.
// All line-side outputs are registered; next-state values are computed one edge ahead.
module serial_tx_framer
  import serial_tx_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int LSB_FIRST    = DEF_LSB_FIRST,
  parameter int PARITY_EN    = DEF_PARITY_EN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              serial_out,
  output logic              bit_strobe,
  output logic              busy,
  output logic              done
);

  localparam int BIT_CNT_W = $clog2(DATA_W + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

  tx_state_e             state_q;
  tx_state_e             state_d;
  logic [DATA_W-1:0]     shreg_q;
  logic [DATA_W-1:0]     shreg_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q;
  logic [BIT_CNT_W-1:0]  bit_cnt_d;
  logic                  parity_q;
  logic                  serial_q;
  logic                  serial_d;
  logic                  busy_q;
  logic                  done_q;
  logic                  handshake;
  logic                  tick_first;
  logic                  tick_last;
  logic                  tick_next_last;

  assign in_ready  = (state_q == ST_IDLE);
  assign handshake = in_valid && in_ready;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk           (clk),
    .reset         (reset),
    .active        (state_q != ST_IDLE),
    .active_next   (state_d != ST_IDLE),
    .tick_first    (tick_first),
    .tick_last     (tick_last),
    .tick_next_last(tick_next_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (handshake) state_d = ST_START;
      ST_START:  if (tick_last) state_d = ST_DATA;
      ST_DATA: begin
        if (tick_last && (bit_cnt_q == LAST_BIT)) begin
          state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: if (tick_last) state_d = ST_STOP;
      ST_STOP:   if (tick_last) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // The shift register always presents the next data bit at its output end.
  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    if (handshake) begin
      shreg_d   = in_data;
      bit_cnt_d = '0;
    end else if ((state_q == ST_DATA) && tick_last) begin
      shreg_d   = (LSB_FIRST != 0) ? (shreg_q >> 1) : (shreg_q << 1);
      bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + BIT_CNT_W'(1);
    end
  end

  always_comb begin
    serial_d = 1'b1;
    case (state_d)
      ST_START:  serial_d = 1'b0;
      ST_DATA:   serial_d = (LSB_FIRST != 0) ? shreg_d[0] : shreg_d[DATA_W-1];
      ST_PARITY: serial_d = parity_q;
      default:   serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      serial_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      if (handshake) begin
        parity_q <= ^in_data;
      end
      serial_q  <= serial_d;
      busy_q    <= (state_d != ST_IDLE);
      // done marks the last cycle of the stop bit, so it is set one edge early.
      done_q    <= (state_d == ST_STOP) && tick_next_last;
    end
  end

  assign serial_out = serial_q;
  assign bit_strobe = tick_first;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_serial_tx_framer.sv
// Scoreboard bench for serial_tx_framer: three instances (default, MSB-first without
// parity, one clock per bit); stimulus queues expected bits, a monitor checks the line.
module tb_serial_tx_framer;

  logic       clk;
  logic       reset;
  logic [7:0] in_data    [3];
  logic       in_valid   [3];
  logic       in_ready   [3];
  logic       serial_out [3];
  logic       bit_strobe [3];
  logic       busy       [3];
  logic       done       [3];

  int cpb_tab [3] = '{4, 4, 1};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bit exp_bits [3][$];
  int exp_done [3][$];
  bit cur      [3];
  bit have_cur [3];
  bit ready_due[3];
  int per_cnt  [3];

  serial_tx_framer #(.DATA_W(8), .CLKS_PER_BIT(4), .LSB_FIRST(1), .PARITY_EN(1)) dut0 (
    .clk(clk), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .serial_out(serial_out[0]), .bit_strobe(bit_strobe[0]),
    .busy(busy[0]), .done(done[0])
  );

  serial_tx_framer #(.DATA_W(8), .CLKS_PER_BIT(4), .LSB_FIRST(0), .PARITY_EN(0)) dut1 (
    .clk(clk), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .serial_out(serial_out[1]), .bit_strobe(bit_strobe[1]),
    .busy(busy[1]), .done(done[1])
  );

  serial_tx_framer #(.DATA_W(8), .CLKS_PER_BIT(1), .LSB_FIRST(1), .PARITY_EN(1)) dut2 (
    .clk(clk), .reset(reset), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .serial_out(serial_out[2]), .bit_strobe(bit_strobe[2]),
    .busy(busy[2]), .done(done[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: one pass per instance on every falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (ready_due[k]) begin
        chk($sformatf("dut%0d_ready_after_done", k), in_ready[k], 1);
        ready_due[k] = 1'b0;
      end
      if (bit_strobe[k]) begin
        if (have_cur[k]) chk($sformatf("dut%0d_period_len", k), per_cnt[k], cpb_tab[k]);
        chk($sformatf("dut%0d_strobe_expected", k), int'(exp_bits[k].size() != 0), 1);
        if (exp_bits[k].size() != 0) cur[k] = exp_bits[k].pop_front();
        have_cur[k] = 1'b1;
        per_cnt[k]  = 1;
      end else if (busy[k]) begin
        per_cnt[k]++;
      end
      if (busy[k]) begin
        chk($sformatf("dut%0d_ready_low_busy", k), in_ready[k], 0);
        if (have_cur[k]) chk($sformatf("dut%0d_line_level", k), serial_out[k], cur[k]);
      end else begin
        chk($sformatf("dut%0d_idle_line", k), serial_out[k], 1);
        chk($sformatf("dut%0d_idle_ready", k), in_ready[k], 1);
        chk($sformatf("dut%0d_idle_strobe", k), bit_strobe[k], 0);
      end
      if (done[k]) begin
        chk($sformatf("dut%0d_done_expected", k), int'(exp_done[k].size() != 0), 1);
        if (exp_done[k].size() != 0) chk($sformatf("dut%0d_done_cycle", k), cyc, exp_done[k].pop_front());
        chk($sformatf("dut%0d_bits_left_at_done", k), exp_bits[k].size(), 0);
        chk($sformatf("dut%0d_stop_period_len", k), per_cnt[k], cpb_tab[k]);
        ready_due[k] = 1'b1;
        have_cur[k]  = 1'b0;
      end
    end
  end

  // frame: transmitted bit sequence, start bit first, hand-derived from d.
  task automatic send(input int k, input logic [7:0] d, input string frame, output int hs_edge);
    int n;
    @(negedge clk);
    in_data[k]  = d;
    in_valid[k] = 1'b1;
    n = 0;
    while (!in_ready[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("dut%0d_handshake_wait", k), in_ready[k], 1);
    hs_edge = cyc + 1;
    for (int i = 0; i < frame.len(); i++) exp_bits[k].push_back(frame[i] == "1");
    exp_done[k].push_back(hs_edge + frame.len() * cpb_tab[k] - 1);
    $display("tx dut%0d data=%02h frame=%s handshake_edge=%0d", k, d, frame, hs_edge);
    @(posedge clk);
  endtask

  task automatic idle(input int k);
    @(negedge clk);
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_frames(input int k);
    int n;
    n = 0;
    while ((exp_done[k].size() != 0 || busy[k]) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("dut%0d_frame_timeout", k), int'(n < 400), 1);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int h1, h2, n;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data[k]  = 8'h00;
      in_valid[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dut%0d_rst_serial", k), serial_out[k], 1);
      chk($sformatf("dut%0d_rst_ready", k), in_ready[k], 1);
      chk($sformatf("dut%0d_rst_busy", k), busy[k], 0);
      chk($sformatf("dut%0d_rst_done", k), done[k], 0);
      chk($sformatf("dut%0d_rst_strobe", k), bit_strobe[k], 0);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 0xA5, LSB first: done in cycle 44, ready in cycle 45.
    send(0, 8'hA5, "01010010101", h1);
    idle(0);
    wait_frames(0);

    // 0x01 then 0x80 with in_valid held: handshakes 45 cycles apart.
    send(0, 8'h01, "01000000011", h1);
    send(0, 8'h80, "00000000111", h2);
    chk("dut0_b2b_spacing", h2 - h1, 45);
    idle(0);
    wait_frames(0);

    // MSB first, no parity: 0xC3 then 0x96; done in cycle 40.
    send(1, 8'hC3, "0110000111", h1);
    idle(1);
    wait_frames(1);
    send(1, 8'h96, "0100101101", h1);
    idle(1);
    wait_frames(1);

    // One clock per bit: 11-cycle frames, back-to-back spacing 12.
    send(2, 8'hFF, "01111111101", h1);
    send(2, 8'h6B, "01101011011", h2);
    chk("dut2_b2b_spacing", h2 - h1, 12);
    idle(2);
    wait_frames(2);

    // Abort 0x05 in cycle 20 (data bit 3 = 0 on the line).
    send(0, 8'h05, "01010000001", h1);
    idle(0);
    n = 0;
    while (cyc != h1 + 19 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("dut0_abort_reach_cycle20", cyc, h1 + 19);
    chk("dut0_pre_abort_line", serial_out[0], 0);
    reset = 1'b1;
    exp_bits[0].delete();
    exp_done[0].delete();
    have_cur[0] = 1'b0;
    #1;
    chk("dut0_abort_serial", serial_out[0], 1);
    chk("dut0_abort_busy", busy[0], 0);
    chk("dut0_abort_ready", in_ready[0], 1);
    chk("dut0_abort_done", done[0], 0);
    in_valid[0] = 1'b1;
    in_data[0]  = 8'hFF;
    repeat (3) @(negedge clk);
    chk("dut0_in_reset_busy", busy[0], 0);
    in_valid[0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("dut0_after_release_ready", in_ready[0], 1);
    send(0, 8'h3C, "00011110001", h1);
    idle(0);
    wait_frames(0);

    // Input churn during a frame must not disturb it or start another.
    send(0, 8'h5A, "00101101001", h1);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      in_data[0]  = 8'($urandom);
      in_valid[0] = i[0];
    end
    in_valid[0] = 1'b0;
    wait_frames(0);
    repeat (5) @(negedge clk);

    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dut%0d_leftover_bits", k), exp_bits[k].size(), 0);
      chk($sformatf("dut%0d_leftover_done", k), exp_done[k].size(), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
